// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin arbiter sharing one UART tx serializer between NUM_REQ byte
//           sources; a granted requester keeps tx until its last byte has left.
// Latency : req_valid seen in IDLE/HOLD -> uout_valid/req_ready next cycle; tx_valid ->
//           IDLE/HOLD next cycle, so the earliest following launch is 2 cycles after tx_valid.
// Backpressure: req_ready is a one-cycle consume pulse; a byte is only taken when the arbiter
//           is in IDLE/HOLD, so requesters simply hold valid/data/last until req_ready.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_valid/data/last  per-requester byte offer (data slice i = [8*i+7:8*i])
//   req_ready         one-cycle pulse: byte of requester i was consumed at the previous edge
//   grant             one-hot current owner of tx, 0 when idle
//   tx_data           byte presented to tx, held stable while the frame is sent
//   uout_valid        one-cycle launch strobe to tx
//   tx_valid          one-cycle frame-done pulse from tx
//   busy              arbiter not in IDLE
//   err               one-cycle watchdog abort pulse
//
// Optional feature: define UART_ARB_WDT_EN to enable the launch-to-tx_valid watchdog
// (WDT_CYCLES cycles). Without it err is tied low and WAIT lasts until tx_valid.

module uart_tx_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int WDT_CYCLES = 20000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [7:0]             tx_data,
  output logic                   uout_valid,
  input  logic                   tx_valid,
  output logic                   busy,
  output logic                   err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic                 uout_valid_q, uout_valid_d;

`ifdef UART_ARB_WDT_EN
  logic [31:0]          wdt_q, wdt_d;
  logic                 err_q, err_d;
`endif

  logic                 pick_vld;
  logic [PTR_W-1:0]     pick_idx;
  logic                 load;
  logic [PTR_W-1:0]     load_idx;

  // Requester index modulo NUM_REQ; inputs never exceed 2*NUM_REQ-2.
  function automatic logic [PTR_W-1:0] wrap_idx(input int k);
    return PTR_W'(k % NUM_REQ);
  endfunction

  // Round-robin search starting at ptr_q, first valid requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_valid[wrap_idx(int'(ptr_q) + i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(ptr_q) + i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    tx_data_d    = tx_data_q;
    last_d       = last_q;
    req_ready_d  = '0;
    uout_valid_d = 1'b0;
    load         = 1'b0;
    load_idx     = owner_q;
`ifdef UART_ARB_WDT_EN
    wdt_d        = wdt_q;
    err_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          load     = 1'b1;
          load_idx = pick_idx;
        end
      end
      S_WAIT: begin
        if (tx_valid) begin
          if (last_q) begin
            grant_d = '0;
            ptr_d   = wrap_idx(int'(owner_q) + 1);
            state_d = S_IDLE;
          end else begin
            state_d = S_HOLD;
          end
        end
`ifdef UART_ARB_WDT_EN
        // Frame never completed: drop the rest of the packet and move on.
        else if (wdt_q == 32'(WDT_CYCLES - 1)) begin
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = wrap_idx(int'(owner_q) + 1);
          state_d = S_IDLE;
        end else begin
          wdt_d = wdt_q + 32'd1;
        end
`endif
      end
      S_HOLD: begin
        // Packet lock: only the current owner may continue.
        if (req_valid[owner_q]) begin
          load     = 1'b1;
          load_idx = owner_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      owner_d      = load_idx;
      grant_d      = NUM_REQ'(1) << load_idx;
      req_ready_d  = NUM_REQ'(1) << load_idx;
      tx_data_d    = req_data[8*load_idx +: 8];
      last_d       = req_last[load_idx];
      uout_valid_d = 1'b1;
      state_d      = S_WAIT;
`ifdef UART_ARB_WDT_EN
      wdt_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      req_ready_q  <= '0;
      tx_data_q    <= 8'h00;
      last_q       <= 1'b0;
      uout_valid_q <= 1'b0;
`ifdef UART_ARB_WDT_EN
      wdt_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      tx_data_q    <= tx_data_d;
      last_q       <= last_d;
      uout_valid_q <= uout_valid_d;
`ifdef UART_ARB_WDT_EN
      wdt_q        <= wdt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign req_ready  = req_ready_q;
  assign tx_data    = tx_data_q;
  assign uout_valid = uout_valid_q;
  assign busy       = (state_q != S_IDLE);

`ifdef UART_ARB_WDT_EN
  assign err = err_q;
`else
  // Watchdog compiled out; the timeout parameter has no consumer.
  logic wdt_cycles_unused;
  assign wdt_cycles_unused = (WDT_CYCLES != 0);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        uout_valid;
  logic        tx_valid;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  uart_tx_arbiter #(.NUM_REQ(2), .WDT_CYCLES(50)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .grant      (grant),
    .tx_data    (tx_data),
    .uout_valid (uout_valid),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00; tx_valid = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a launch strobe and reports what was launched.
  task automatic wait_launch(output logic [7:0] d, output logic [1:0] g,
                             output logic [1:0] r, output bit ok);
    ok = 1'b0; d = 8'h00; g = 2'b00; r = 2'b00;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (uout_valid === 1'b1) begin
        ok = 1'b1; d = tx_data; g = grant; r = req_ready;
      end
    end
  endtask

  // Serializer model: frame finishes a few cycles after launch.
  task automatic pulse_tx();
    step(); step();
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({grant, req_ready, tx_data, uout_valid, busy, err} !== 15'd0) begin
      bad++;
      $display("FAIL reset_state got grant=%b rdy=%b data=%h uv=%b busy=%b err=%b need all 0",
               grant, req_ready, tx_data, uout_valid, busy, err);
    end
  endtask

  task automatic test_single();
    logic [7:0] d; logic [1:0] g, r; bit ok;
    do_reset();
    req_valid = 2'b01; req_data = 16'h00AB; req_last = 2'b01;
    wait_launch(d, g, r, ok);
    total++;
    if (!ok || d !== 8'hAB || g !== 2'b01 || r !== 2'b01 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_launch got ok=%0d data=%h grant=%b rdy=%b busy=%b need 1 ab 01 01 1",
               ok, d, g, r, busy);
    end
    req_valid = 2'b00;
    step();
    total++;
    if (uout_valid !== 1'b0 || req_ready !== 2'b00 || grant !== 2'b01 || tx_data !== 8'hAB) begin
      bad++;
      $display("FAIL t1_wait got uv=%b rdy=%b grant=%b data=%h need 0 00 01 ab",
               uout_valid, req_ready, grant, tx_data);
    end
    pulse_tx();
    total++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_done got grant=%b busy=%b need 00 0", grant, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d; logic [1:0] g, r; bit ok;
    do_reset();
    req_valid = 2'b11; req_data = 16'h2211; req_last = 2'b11;
    wait_launch(d, g, r, ok);
    total++;
    if (!ok || d !== 8'h11 || g !== 2'b01 || r !== 2'b01) begin
      bad++;
      $display("FAIL t2_first got ok=%0d data=%h grant=%b rdy=%b need 1 11 01 01", ok, d, g, r);
    end
    // req0 offers a new byte while req1 is still waiting: ptr=1 favours req1.
    req_data = 16'h2233;
    pulse_tx();
    wait_launch(d, g, r, ok);
    total++;
    if (!ok || d !== 8'h22 || g !== 2'b10 || r !== 2'b10) begin
      bad++;
      $display("FAIL t2_second got ok=%0d data=%h grant=%b rdy=%b need 1 22 10 10", ok, d, g, r);
    end
    req_valid = 2'b01;
    pulse_tx();
    wait_launch(d, g, r, ok);
    total++;
    if (!ok || d !== 8'h33 || g !== 2'b01) begin
      bad++;
      $display("FAIL t2_third got ok=%0d data=%h grant=%b need 1 33 01", ok, d, g);
    end
    req_valid = 2'b00;
    pulse_tx();
  endtask

  task automatic test_packet_lock();
    logic [7:0] d; logic [1:0] g, r; bit ok;
    logic [7:0] exp_d [4] = '{8'h31, 8'h32, 8'h0A, 8'h55};
    logic [1:0] exp_g [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    req_valid = 2'b11; req_data = 16'h5531; req_last = 2'b10;
    for (int k = 0; k < 4; k++) begin
      wait_launch(d, g, r, ok);
      total++;
      if (!ok || d !== exp_d[k] || g !== exp_g[k] || r !== exp_g[k]) begin
        bad++;
        $display("FAIL t3_byte%0d got ok=%0d data=%h grant=%b rdy=%b need 1 %h %b %b",
                 k, ok, d, g, r, exp_d[k], exp_g[k], exp_g[k]);
      end
      case (k)
        0: req_data = 16'h5532;
        1: begin req_data = 16'h550A; req_last = 2'b11; end
        2: req_valid = 2'b10;
        default: req_valid = 2'b00;
      endcase
      pulse_tx();
      if (k == 0) begin
        total++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
          bad++;
          $display("FAIL t3_hold got grant=%b busy=%b need 01 1", grant, busy);
        end
      end
    end
    total++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t3_end got grant=%b busy=%b need 00 0", grant, busy);
    end
  endtask

  task automatic test_stray_tx_valid();
    do_reset();
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    step();
    total++;
    if ({grant, req_ready, tx_data, uout_valid, busy, err} !== 15'd0) begin
      bad++;
      $display("FAIL t4_idle got grant=%b rdy=%b data=%h uv=%b busy=%b err=%b need all 0",
               grant, req_ready, tx_data, uout_valid, busy, err);
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] d; logic [1:0] g, r; bit ok;
    do_reset();
    req_valid = 2'b01; req_data = 16'h0041; req_last = 2'b00;
    wait_launch(d, g, r, ok);
    req_valid = 2'b00;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({grant, req_ready, tx_data, uout_valid, busy, err} !== 15'd0) begin
      bad++;
      $display("FAIL t5_reset got grant=%b rdy=%b data=%h uv=%b busy=%b err=%b need all 0",
               grant, req_ready, tx_data, uout_valid, busy, err);
    end
    req_valid = 2'b10; req_data = 16'h7700; req_last = 2'b10;
    wait_launch(d, g, r, ok);
    total++;
    if (!ok || d !== 8'h77 || g !== 2'b10 || r !== 2'b10) begin
      bad++;
      $display("FAIL t5_after got ok=%0d data=%h grant=%b rdy=%b need 1 77 10 10", ok, d, g, r);
    end
    req_valid = 2'b00;
    pulse_tx();
  endtask

  task automatic test_watchdog();
    logic [7:0] d; logic [1:0] g, r; bit ok;
    do_reset();
    req_valid = 2'b01; req_data = 16'h00C3; req_last = 2'b01;
    wait_launch(d, g, r, ok);
    req_valid = 2'b00;
`ifdef UART_ARB_WDT_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
        step();
        n++;
        if (err === 1'b1) seen = 1'b1;
      end
      total++;
      if (!ok || !seen || n != 50 || grant !== 2'b00) begin
        bad++;
        $display("FAIL t6_wdt got launched=%0d err_seen=%0d cycles=%0d grant=%b need 1 1 50 00",
                 ok, seen, n, grant);
      end
      step();
      total++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL t6_wdt_pulse got err=%b busy=%b need 0 0", err, busy);
      end
    end
`else
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        step();
        if (err !== 1'b0) seen = 1'b1;
      end
      total++;
      if (!ok || seen || grant !== 2'b01 || busy !== 1'b1) begin
        bad++;
        $display("FAIL t6_nowdt got launched=%0d err_seen=%0d grant=%b busy=%b need 1 0 01 1",
                 ok, seen, grant, busy);
      end
      pulse_tx();
    end
`endif
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_data = 16'h0000; req_last = 2'b00; tx_valid = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_stray_tx_valid();
    test_mid_reset();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
